vector_beat_sequencer: RTL and testbench
========================================

Name: vector_beat_sequencer

Overview:
Downstream consumer of the vector CSR stage (vsew, vlmul, vl, vill).
On each vector arithmetic/load-store instruction, it walks the register group one register per beat, VLENB bytes wide.
Per beat it emits the register offset, the first element index and a per-byte body mask to the vector lane datapath over a valid/ready handshake.
It holds the scalar pipeline while busy and reports completion.

Parameters:
VLEN, 64, vector register length in bits.
VLENB, 8, vector register length in bytes (VLEN/8); width of byte mask.

Ports:
clk  input  1  clock
reset_n  input  1  asynchronous active-low reset
start_i  input  1  vector instruction issued; sampled only in IDLE
kill_i  input  1  synchronous abort (pipeline flush)
vsew_i  input  3  vew_e element width (EW8=0..EW64=3)
vlmul_i  input  3  vlmul_e (LMUL_1=0,2=1,4=2,8=3, 1_8=5, 1_4=6, 1_2=7)
vl_i  input  32  current vl
vill_i  input  1  vtype illegal flag
beat_valid_o  output  1  beat outputs valid
beat_ready_i  input  1  datapath accepts beat
vreg_offset_o  output  3  register index within group
elem_base_o  output  32  index of first element in this beat
byte_mask_o  output  VLENB  1 = body byte, 0 = tail byte
last_o  output  1  current beat is final
hold_o  output  1  stall scalar pipeline
done_o  output  1  one-cycle completion pulse
illegal_o  output  1  one-cycle pulse: start with vill set

Behaviour:
- Reset (async): state IDLE. All outputs 0. Snapshot registers 0.
- Snapshot on start: in IDLE, start_i=1 latches vsew_i, vlmul_i, vl_i.
  - Later changes on these inputs are ignored until return to IDLE.
  - start_i outside IDLE is ignored.
- Derived values:
  - epr = VLENB >> vsew (elements per register).
  - nregs = 1 << vlmul for vlmul 0..3; nregs = 1 for fractional (5,6,7).
  - Encoding 4 is treated as nregs=1.
- States: IDLE, BUSY, FIN.
  - IDLE -> FIN on start with vill_i=1: illegal_o=1 next cycle, no beats.
  - IDLE -> FIN on start with vl_i=0: no beats.
  - IDLE -> BUSY on any other start, beat counter k=0.
  - BUSY: beat_valid_o=1.
    - On valid&ready with last_o=1 -> FIN; otherwise k++.
    - Outputs are stable while valid&!ready.
  - FIN: done_o=1 for exactly one cycle (also asserted on the vill path), then -> IDLE.
- Latency: start at cycle 0 -> first beat_valid_o in cycle 1 (registered outputs). done_o is in the cycle after the final handshake.
- Beat contents:
  - vreg_offset_o = k.
  - elem_base_o = k*epr.
  - byte_mask_o[b] = ((elem_base_o + (b >> vsew)) < vl).
  - All 32-bit compares are unsigned.
- last_o:
  - Without feature: last_o = (k == nregs-1).
  - With feature: see Optional Feature.
- hold_o = (state != IDLE), including FIN, so the pipeline resumes the cycle after done_o.
- vl larger than nregs*epr: every byte of every beat is body; no error.
- kill_i: has priority over everything.
  - In any state it forces IDLE next cycle.
  - No done_o and no illegal_o; beat_valid_o drops next cycle.
  - kill_i together with start_i in IDLE: start is discarded.
- Same-cycle start in FIN: ignored (block is not in IDLE).

Optional Feature:
- Macro VSEQ_TAIL_SKIP_EN.
- Defined:
  - last_o = (k == nregs-1) || ((k+1)*epr >= vl).
  - Registers wholly in tail are never issued.
- Undefined:
  - All nregs beats are issued.
  - Fully-tail beats carry byte_mask_o = 0 so the datapath can apply tail policy.

Test Plan:
- EW16, LMUL_2, vl=6, ready=1 -> beat0 {off0, base0, mask 0xFF}; beat1 {off1, base4, mask 0x0F, last}; done_o one cycle later; hold_o high cycles 1..3.
- EW8, LMUL_4, vl=9 -> with VSEQ_TAIL_SKIP_EN: masks 0xFF, 0x01(last); without it: masks 0xFF, 0x01, 0x00, 0x00(last at off3).
- EW8, LMUL_1_2, vl=3 -> single beat off0, mask 0x07, last; vl=0 -> no beat_valid_o, done_o in cycle 1.
- EW32, LMUL_2, vl=3, beat_ready_i low 3 cycles on beat0 -> outputs unchanged while stalled; beat1 base2 mask 0x0F.
- Start with vill_i=1 -> illegal_o and done_o in cycle 1, no beats; start_i while BUSY is ignored.
- EW8, LMUL_8, vl=64, kill_i during beat2 -> IDLE next cycle, no done_o; a new start afterwards begins at off0.

Source files
------------

// File: rtl/vector_beat_sequencer_if.sv
// Beat handshake bundle between the vector beat sequencer
// and the vector lane datapath.
interface vector_beat_sequencer_if #(
  parameter int VLENB = 8
) ();
  logic             beat_valid;
  logic             beat_ready;
  logic [2:0]       vreg_offset;
  logic [31:0]      elem_base;
  logic [VLENB-1:0] byte_mask;
  logic             last;

  modport master (
    output beat_valid,
    input  beat_ready,
    output vreg_offset,
    output elem_base,
    output byte_mask,
    output last
  );

  modport slave (
    input  beat_valid,
    output beat_ready,
    input  vreg_offset,
    input  elem_base,
    input  byte_mask,
    input  last
  );
endinterface

// File: rtl/vector_beat_sequencer.sv
// Walks a vector register group one register per beat.
// VSEQ_TAIL_SKIP_EN: stop after the last register holding body bytes.
module vector_beat_sequencer #(
  parameter int VLEN  = 64,
  parameter int VLENB = VLEN / 8
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start_i,
  input  logic        kill_i,
  input  logic [2:0]  vsew_i,
  input  logic [2:0]  vlmul_i,
  input  logic [31:0] vl_i,
  input  logic        vill_i,
  vector_beat_sequencer_if.master beat,
  output logic        hold_o,
  output logic        done_o,
  output logic        illegal_o
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_FIN
  } state_e;

  state_e      state_q, state_d;
  logic [2:0]  sew_q, sew_d;
  logic [2:0]  lmul_q, lmul_d;
  logic [31:0] vl_q, vl_d;
  logic [2:0]  k_q, k_d;
  logic        ill_q, ill_d;

  logic [31:0]      epr;
  logic [3:0]       nregs;
  logic [31:0]      base;
  logic [VLENB-1:0] mask;
  logic             last;
  logic             busy;
  logic             fire;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      sew_q   <= '0;
      lmul_q  <= '0;
      vl_q    <= '0;
      k_q     <= '0;
      ill_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sew_q   <= sew_d;
      lmul_q  <= lmul_d;
      vl_q    <= vl_d;
      k_q     <= k_d;
      ill_q   <= ill_d;
    end
  end

  always_comb begin
    epr = 32'(VLENB) >> sew_q;
    case (lmul_q)
      3'd0:    nregs = 4'd1;
      3'd1:    nregs = 4'd2;
      3'd2:    nregs = 4'd4;
      3'd3:    nregs = 4'd8;
      default: nregs = 4'd1;
    endcase
    base = 32'(k_q) * epr;
    for (int b = 0; b < VLENB; b++) begin
      mask[b] = (base + (32'(b) >> sew_q)) < vl_q;
    end
`ifdef VSEQ_TAIL_SKIP_EN
    last = ({1'b0, k_q} == nregs - 4'd1)
        || (((32'(k_q) + 32'd1) * epr) >= vl_q);
`else
    last = ({1'b0, k_q} == nregs - 4'd1);
`endif
  end

  assign busy = (state_q == S_BUSY);
  assign fire = busy && beat.beat_ready;

  always_comb begin
    state_d = state_q;
    sew_d   = sew_q;
    lmul_d  = lmul_q;
    vl_d    = vl_q;
    k_d     = k_q;
    ill_d   = 1'b0;
    if (kill_i) begin
      state_d = S_IDLE;
      k_d     = '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (start_i) begin
            sew_d  = vsew_i;
            lmul_d = vlmul_i;
            vl_d   = vl_i;
            k_d    = '0;
            if (vill_i) begin
              state_d = S_FIN;
              ill_d   = 1'b1;
            end else if (vl_i == 32'd0) begin
              state_d = S_FIN;
            end else begin
              state_d = S_BUSY;
            end
          end
        end
        S_BUSY: begin
          if (fire) begin
            if (last) state_d = S_FIN;
            else      k_d = k_q + 3'd1;
          end
        end
        S_FIN: begin
          state_d = S_IDLE;
          k_d     = '0;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Beat fields are forced to zero outside BUSY so idle outputs read as 0.
  assign beat.beat_valid  = busy;
  assign beat.vreg_offset = busy ? k_q : 3'd0;
  assign beat.elem_base   = busy ? base : 32'd0;
  assign beat.byte_mask   = busy ? mask : '0;
  assign beat.last        = busy && last;

  assign hold_o    = (state_q != S_IDLE);
  assign done_o    = (state_q == S_FIN);
  assign illegal_o = ill_q;

endmodule

// File: tb/tb_vector_beat_sequencer.sv
// Directed checks for vector_beat_sequencer.
// Expected values hand-derived from VLENB=8 register geometry.
module tb_vector_beat_sequencer;

  logic        clk;
  logic        reset_n;
  logic        start_i;
  logic        kill_i;
  logic [2:0]  vsew_i;
  logic [2:0]  vlmul_i;
  logic [31:0] vl_i;
  logic        vill_i;
  logic        hold_o;
  logic        done_o;
  logic        illegal_o;

  int n_chk;
  int n_pass;

  vector_beat_sequencer_if #(.VLENB(8)) bif ();

  vector_beat_sequencer #(
    .VLEN (64),
    .VLENB(8)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .start_i  (start_i),
    .kill_i   (kill_i),
    .vsew_i   (vsew_i),
    .vlmul_i  (vlmul_i),
    .vl_i     (vl_i),
    .vill_i   (vill_i),
    .beat     (bif.master),
    .hold_o   (hold_o),
    .done_o   (done_o),
    .illegal_o(illegal_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input string tag,
                      input logic [2:0] off,
                      input logic [31:0] base,
                      input logic [7:0] mask,
                      input logic lst);
    chk({tag, ".valid"}, 32'(bif.beat_valid), 32'd1);
    chk({tag, ".off"}, 32'(bif.vreg_offset), 32'(off));
    chk({tag, ".base"}, bif.elem_base, base);
    chk({tag, ".mask"}, 32'(bif.byte_mask), 32'(mask));
    chk({tag, ".last"}, 32'(bif.last), 32'(lst));
    chk({tag, ".hold"}, 32'(hold_o), 32'd1);
  endtask

  task automatic go(input logic [2:0] sew,
                    input logic [2:0] lmul,
                    input logic [31:0] vl,
                    input logic ill);
    vsew_i  = sew;
    vlmul_i = lmul;
    vl_i    = vl;
    vill_i  = ill;
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    vsew_i  = 3'd0;
    vlmul_i = 3'd0;
    vl_i    = 32'd0;
    vill_i  = 1'b0;
  endtask

  task automatic fin(input string tag);
    chk({tag, ".fin.valid"}, 32'(bif.beat_valid), 32'd0);
    chk({tag, ".fin.done"}, 32'(done_o), 32'd1);
    chk({tag, ".fin.hold"}, 32'(hold_o), 32'd1);
    tick();
    chk({tag, ".idle.done"}, 32'(done_o), 32'd0);
    chk({tag, ".idle.hold"}, 32'(hold_o), 32'd0);
  endtask

  initial begin
    n_chk   = 0;
    n_pass  = 0;
    reset_n = 1'b0;
    start_i = 1'b0;
    kill_i  = 1'b0;
    vsew_i  = 3'd0;
    vlmul_i = 3'd0;
    vl_i    = 32'd0;
    vill_i  = 1'b0;
    bif.beat_ready = 1'b1;
    #12;
    chk("rst.valid", 32'(bif.beat_valid), 32'd0);
    chk("rst.last", 32'(bif.last), 32'd0);
    chk("rst.mask", 32'(bif.byte_mask), 32'd0);
    chk("rst.hold", 32'(hold_o), 32'd0);
    chk("rst.done", 32'(done_o), 32'd0);
    chk("rst.ill", 32'(illegal_o), 32'd0);
    reset_n = 1'b1;
    tick();

    // EW16 LMUL_2 vl=6
    go(3'd1, 3'd1, 32'd6, 1'b0);
    beat("t1.b0", 3'd0, 32'd0, 8'hFF, 1'b0);
    tick();
    beat("t1.b1", 3'd1, 32'd4, 8'h0F, 1'b1);
    tick();
    fin("t1");

    // EW8 LMUL_4 vl=9
    go(3'd0, 3'd2, 32'd9, 1'b0);
    beat("t2.b0", 3'd0, 32'd0, 8'hFF, 1'b0);
    tick();
`ifdef VSEQ_TAIL_SKIP_EN
    beat("t2.b1", 3'd1, 32'd8, 8'h01, 1'b1);
    tick();
`else
    beat("t2.b1", 3'd1, 32'd8, 8'h01, 1'b0);
    tick();
    beat("t2.b2", 3'd2, 32'd16, 8'h00, 1'b0);
    tick();
    beat("t2.b3", 3'd3, 32'd24, 8'h00, 1'b1);
    tick();
`endif
    fin("t2");

    // EW8 LMUL_1_2 vl=3, then vl=0
    go(3'd0, 3'd7, 32'd3, 1'b0);
    beat("t3.b0", 3'd0, 32'd0, 8'h07, 1'b1);
    tick();
    fin("t3");
    go(3'd0, 3'd7, 32'd0, 1'b0);
    chk("t3z.ill", 32'(illegal_o), 32'd0);
    fin("t3z");

    // EW32 LMUL_2 vl=3 with stall on beat0
    bif.beat_ready = 1'b0;
    go(3'd2, 3'd1, 32'd3, 1'b0);
    for (int i = 0; i < 3; i++) begin
      beat($sformatf("t4.stall%0d", i), 3'd0, 32'd0, 8'hFF, 1'b0);
      tick();
    end
    bif.beat_ready = 1'b1;
    beat("t4.b0", 3'd0, 32'd0, 8'hFF, 1'b0);
    tick();
    beat("t4.b1", 3'd1, 32'd2, 8'h0F, 1'b1);
    tick();
    fin("t4");

    // vill path
    go(3'd0, 3'd0, 32'd8, 1'b1);
    chk("t5.ill", 32'(illegal_o), 32'd1);
    fin("t5");
    chk("t5.ill_clr", 32'(illegal_o), 32'd0);

    // start while BUSY is ignored
    bif.beat_ready = 1'b0;
    go(3'd0, 3'd1, 32'd16, 1'b0);
    go(3'd0, 3'd0, 32'd1, 1'b0);
    beat("t6.b0", 3'd0, 32'd0, 8'hFF, 1'b0);
    bif.beat_ready = 1'b1;
    tick();
    beat("t6.b1", 3'd1, 32'd8, 8'hFF, 1'b1);
    tick();
    fin("t6");

    // kill during beat2
    go(3'd0, 3'd3, 32'd64, 1'b0);
    beat("t7.b0", 3'd0, 32'd0, 8'hFF, 1'b0);
    tick();
    beat("t7.b1", 3'd1, 32'd8, 8'hFF, 1'b0);
    tick();
    beat("t7.b2", 3'd2, 32'd16, 8'hFF, 1'b0);
    kill_i = 1'b1;
    tick();
    kill_i = 1'b0;
    chk("t7.kill.valid", 32'(bif.beat_valid), 32'd0);
    chk("t7.kill.done", 32'(done_o), 32'd0);
    chk("t7.kill.hold", 32'(hold_o), 32'd0);
    tick();
    chk("t7.kill.done2", 32'(done_o), 32'd0);
    go(3'd0, 3'd0, 32'd5, 1'b0);
    beat("t7.new", 3'd0, 32'd0, 8'h1F, 1'b1);
    tick();
    fin("t7");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
